scan_sel_5: RTL and testbench
=============================

SCAN_SEL_5 -- requirements
Module: scan_sel_5

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 5, the number of mux channels scanned (fixed at 5 for this block).
REQ-002 The block SHALL have parameter DWELL_W, default 4, the width of the dwell input.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port en, input, 1: scan enable; level-sensitive.
REQ-006 Port mask, input, 5: channel enable bits; bit i = 1 includes channel i in the scan.
REQ-007 Port dwell, input, DWELL_W: extra cycles per channel; a channel is held for dwell+1 cycles.
REQ-008 Port mux_out, input, 1: the output of the downstream 5x1 mux, which is driven by sel.
REQ-009 Port sel, output, 3: registered select to the 5x1 mux; values SHALL be 0..4 only.
REQ-010 Port busy, output, 1: high while in SCAN.
REQ-011 Port frame, output, 5: last completed frame; bit i = sampled mux_out for channel i.
REQ-012 Port frame_valid, output, 1: one-cycle pulse when frame updates.

Function
REQ-013 The block SHALL use an FSM with states IDLE, SCAN and DONE.
REQ-014 IDLE: if en=1 at an edge, the block SHALL latch mask and dwell, set sel to the lowest set mask bit, clear the dwell counter, clear the shadow frame and go to SCAN.
REQ-015 In SCAN, the counter SHALL increment each cycle; when counter==dwell_latched, mux_out SHALL be sampled into shadow[sel].
REQ-016 At that same edge, sel SHALL advance to the next higher set bit of mask_latched and the counter SHALL clear; if no higher set bit exists, the state SHALL go to DONE.
REQ-017 Masked channels SHALL never be driven on sel, and their frame bits SHALL be 0.
REQ-018 On entry to DONE, frame SHALL load from shadow and frame_valid SHALL be 1 for exactly that cycle.
REQ-019 From DONE, the next edge SHALL restart the scan as in REQ-014 if en=1, otherwise go to IDLE.
REQ-020 Latency: frame_valid SHALL rise at edge 1 + sum over enabled channels of (dwell+1), counted from the first edge with en=1 in IDLE; all 5 channels with dwell=0 gives edge 6.
REQ-021 If mask=0 when latched, the block SHALL go from IDLE directly to DONE with frame=0 and pulse frame_valid.
REQ-022 If en falls during SCAN, the block SHALL go to IDLE at the next edge with no frame_valid; frame SHALL keep its previous value and sel SHALL hold its last value.
REQ-023 Changes to mask or dwell during a scan SHALL take effect only at the next scan start.
REQ-024 dwell at its maximum value (15) SHALL hold each channel for 16 cycles, with no counter wrap before the sample.

Reset
REQ-025 While rst_n=0, the block SHALL force state=IDLE, sel=0, counter=0, shadow=0, frame=0, frame_valid=0, busy=0, latched mask=0 and latched dwell=0, independent of clk.
REQ-026 Reset asserted mid-scan SHALL abort the scan immediately; after release, the block SHALL behave as from power-up.

Structure
REQ-027 Shared package scan_pkg SHALL hold NUM_CH=5, SEL_W=3 and the FSM state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2).
REQ-028 A combinational sub-module next_ch_5 SHALL return, from (mask, current channel, start flag), the next enabled channel index and a none-left flag.

Verification
REQ-029 rst_n low then high; en=1, mask=11111, dwell=0, mux_out forced to the channel pattern 1,0,1,1,0 -> sel goes 0,1,2,3,4; frame_valid at edge 6; frame=01101.
REQ-030 mask=10101, dwell=2 -> sel visits 0,2,4 only, each for 3 cycles; frame_valid at edge 10; frame bits 1 and 3 are 0.
REQ-031 mask=00000, en=1 -> frame_valid at edge 1; frame=00000; busy never high.
REQ-032 en dropped in the 3rd cycle of SCAN -> IDLE at the next edge, no frame_valid, frame unchanged from the prior scan.
REQ-033 rst_n pulsed low mid-scan, asynchronously between edges -> all outputs 0 immediately; after release with en=1, a full frame completes at edge 6.
REQ-034 Checker run on every cycle of all scenarios: en held high across scans gives back-to-back frame_valid pulses spaced 6 cycles apart (mask=11111, dwell=0), and sel is never 5..7.

Source files
------------

// File: rtl/scan_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : scan_pkg                                               |
// | Purpose : shared constants and FSM state encoding for the        |
// |           5-channel mux scanner (scan_sel_5, next_ch_5).         |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package scan_pkg;

  localparam int NUM_CH = 5;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : scan_pkg
`default_nettype wire

// File: rtl/next_ch_5.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : next_ch_5                                              |
// | Purpose : combinational channel picker. Returns the next enabled |
// |           channel after 'cur', or the lowest enabled channel     |
// |           when 'start' is set.                                   |
// | Ports   : mask  [NUM_CH-1:0] in  - enabled channels              |
// |           cur   [SEL_W-1:0]  in  - channel currently selected    |
// |           start              in  - pick lowest enabled channel   |
// |           nxt   [SEL_W-1:0]  out - chosen channel (0 if none)    |
// |           none               out - no qualifying channel exists  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module next_ch_5
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  input  logic              start,
  output logic [SEL_W-1:0]  nxt,
  output logic              none
);

  // Walk from the top down so the last qualifying hit is the lowest index.
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (start || (SEL_W'(i) > cur))) begin
        nxt  = SEL_W'(i);
        none = 1'b0;
      end
    end
  end

endmodule : next_ch_5
`default_nettype wire

// File: rtl/scan_sel_5.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : scan_sel_5                                             |
// | Purpose : scans the enabled inputs of a downstream 5x1 mux,      |
// |           holding each channel dwell+1 cycles, sampling the mux  |
// |           output on the last cycle, and publishing a frame.      |
// | Ports   : clk, rst_n (async, active-low)                         |
// |           en          in  - scan enable (level)                  |
// |           mask  [5]   in  - channel enables                      |
// |           dwell [W]   in  - extra hold cycles per channel        |
// |           mux_out     in  - downstream mux output                |
// |           sel   [3]   out - registered mux select (0..4)         |
// |           busy        out - high while scanning                  |
// |           frame [5]   out - last completed frame                 |
// |           frame_valid out - one-cycle pulse on frame update      |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module scan_sel_5
  import scan_pkg::SEL_W, scan_pkg::state_t, scan_pkg::IDLE, scan_pkg::SCAN, scan_pkg::DONE;
#(
  parameter int NUM_CH  = 5,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_CH-1:0]  mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_out,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic [NUM_CH-1:0]  frame,
  output logic               frame_valid
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_CH-1:0]    r_mask;
  logic [DWELL_W-1:0]   r_dwell;
  logic [DWELL_W-1:0]   r_cnt;
  logic [NUM_CH-1:0]    r_shadow;

  logic                 w_start;
  logic                 w_sample;
  logic                 w_pick_lowest;
  logic [NUM_CH-1:0]    w_ch_mask;
  logic [SEL_W-1:0]     w_nxt_ch;
  logic                 w_none;
  logic [NUM_CH-1:0]    w_hit;

  // Outside SCAN the picker looks at the live mask, since that is the
  // value about to be latched; inside SCAN only the latched copy counts.
  assign w_pick_lowest = (r_state != SCAN);
  assign w_ch_mask     = w_pick_lowest ? mask : r_mask;

  next_ch_5 u_next_ch (
    .mask  (w_ch_mask),
    .cur   (sel),
    .start (w_pick_lowest),
    .nxt   (w_nxt_ch),
    .none  (w_none)
  );

  // One-hot placement of the sampled mux output at the current channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_hit
    assign w_hit[i] = mux_out && (sel == SEL_W'(i));
  end

  assign busy = (r_state == SCAN);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (en) begin
          w_start     = 1'b1;
          w_state_nxt = w_none ? DONE : SCAN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SCAN: begin
        if (!en) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == r_dwell) begin
          w_sample = 1'b1;
          if (w_none) w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mask      <= '0;
      r_dwell     <= '0;
      r_cnt       <= '0;
      r_shadow    <= '0;
      sel         <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      frame_valid <= 1'b0;
      if (w_start) begin
        r_mask   <= mask;
        r_dwell  <= dwell;
        r_cnt    <= '0;
        r_shadow <= '0;
        if (w_none) begin
          // Empty mask: publish an all-zero frame straight away.
          frame       <= '0;
          frame_valid <= 1'b1;
        end else begin
          sel <= w_nxt_ch;
        end
      end else if (w_sample) begin
        r_cnt    <= '0;
        r_shadow <= r_shadow | w_hit;
        if (w_none) begin
          // Last channel: fold its sample in directly so frame is complete.
          frame       <= r_shadow | w_hit;
          frame_valid <= 1'b1;
        end else begin
          sel <= w_nxt_ch;
        end
      end else if ((r_state == SCAN) && en) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule : scan_sel_5
`default_nettype wire

// File: tb/tb_scan_sel_5.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_scan_sel_5                                          |
// | Purpose : self-checking bench for scan_sel_5 with a scan-plan    |
// |           reference model and directed plus random stimulus.     |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_scan_sel_5;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [4:0] mask;
  logic [3:0] dwell;
  logic       mux_out;
  logic [2:0] sel;
  logic       busy;
  logic [4:0] frame;
  logic       frame_valid;

  logic [4:0] pat;   // value each mux input currently presents

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  scan_sel_5 #(.NUM_CH(5), .DWELL_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mask        (mask),
    .dwell       (dwell),
    .mux_out     (mux_out),
    .sel         (sel),
    .busy        (busy),
    .frame       (frame),
    .frame_valid (frame_valid)
  );

  assign mux_out = (sel < 3'd5) ? pat[sel] : 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model: a scan is a plan of channel slots
  int         m_plan[$];
  int         m_ch;
  bit         m_active;
  logic [2:0] m_sel;
  logic [4:0] m_frame;
  logic [4:0] m_shadow;
  logic       m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_plan.delete();
      m_active = 0;
      m_sel    = 3'd0;
      m_frame  = 5'd0;
      m_shadow = 5'd0;
      m_valid  = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_active) begin
        if (!en) begin
          m_active = 0;
          m_plan.delete();
        end else begin
          m_ch = m_plan.pop_front();
          // Last slot of a channel's run is where the mux is sampled.
          if (m_plan.size() == 0 || m_plan[0] != m_ch) m_shadow[m_ch] = pat[m_ch];
          if (m_plan.size() == 0) begin
            m_frame  = m_shadow;
            m_valid  = 1'b1;
            m_active = 0;
          end else begin
            m_sel = 3'(m_plan[0]);
          end
        end
      end else if (en) begin
        m_plan.delete();
        for (int c = 0; c < 5; c++)
          if (mask[c]) for (int d = 0; d <= int'(dwell); d++) m_plan.push_back(c);
        m_shadow = 5'd0;
        if (m_plan.size() == 0) begin
          m_frame = 5'd0;
          m_valid = 1'b1;
        end else begin
          m_sel    = 3'(m_plan[0]);
          m_active = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sel", 32'(sel), 32'(m_sel));
      chk("busy", 32'(busy), 32'(m_active));
      chk("frame", 32'(frame), 32'(m_frame));
      chk("frame_valid", 32'(frame_valid), 32'(m_valid));
      chk("sel_range", 32'(sel <= 3'd4), 32'd1);
    end
  end

  // ---------------- directed helpers
  logic [2:0] selq[$];

  task automatic run_scan(input logic [4:0] mk, input logic [3:0] dw, input logic [4:0] pt,
                          input int budget, output int vedge, output logic [4:0] vframe,
                          output bit saw_busy);
    @(negedge clk);
    mask = mk; dwell = dw; pat = pt; en = 1'b1;
    vedge = -1; vframe = 5'h1f; saw_busy = 0;
    selq.delete();
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      selq.push_back(sel);
      if (busy) saw_busy = 1;
      if (frame_valid) begin
        vedge  = k;
        vframe = frame;
        break;
      end
    end
    @(negedge clk); en = 1'b0;
    @(negedge clk);
  endtask

  int         ve;
  logic [4:0] vf;
  bit         sb;
  int         fv_edges[$];

  initial begin
    rst_n = 1'b0; en = 1'b0; mask = 5'd0; dwell = 4'd0; pat = 5'd0;
    #12;
    chk_en = 1;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fv", 32'(frame_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // All channels, dwell 0, inputs 1,0,1,1,0 on channels 0..4
    run_scan(5'b11111, 4'd0, 5'b01101, 40, ve, vf, sb);
    chk("s1_edge", 32'(ve), 32'd6);
    chk("s1_frame", 32'(vf), 32'b01101);
    chk("s1_sel_e1", 32'(selq[0]), 32'd0);
    chk("s1_sel_e3", 32'(selq[2]), 32'd2);
    chk("s1_sel_e5", 32'(selq[4]), 32'd4);

    // Empty mask
    run_scan(5'b00000, 4'd3, 5'b11111, 10, ve, vf, sb);
    chk("s3_edge", 32'(ve), 32'd1);
    chk("s3_frame", 32'(vf), 32'd0);
    chk("s3_busy", 32'(sb), 32'd0);

    // Sparse mask, dwell 2
    run_scan(5'b10101, 4'd2, 5'b11111, 40, ve, vf, sb);
    chk("s2_edge", 32'(ve), 32'd10);
    chk("s2_frame", 32'(vf), 32'b10101);
    chk("s2_sel_e1", 32'(selq[0]), 32'd0);
    chk("s2_sel_e3", 32'(selq[2]), 32'd0);
    chk("s2_sel_e4", 32'(selq[3]), 32'd2);
    chk("s2_sel_e7", 32'(selq[6]), 32'd4);
    chk("s2_sel_e9", 32'(selq[8]), 32'd4);

    // en dropped in the third SCAN cycle
    @(negedge clk);
    mask = 5'b11111; dwell = 4'd0; pat = 5'b01010; en = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("drop_sel_e3", 32'(sel), 32'd2);
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_fv", 32'(frame_valid), 32'd0);
    chk("drop_frame", 32'(frame), 32'b10101);
    chk("drop_sel_hold", 32'(sel), 32'd2);
    repeat (4) @(negedge clk);
    chk("drop_frame_later", 32'(frame), 32'b10101);

    // Maximum dwell, single channel
    run_scan(5'b00010, 4'd15, 5'b00010, 40, ve, vf, sb);
    chk("dw15_edge", 32'(ve), 32'd17);
    chk("dw15_frame", 32'(vf), 32'b00010);

    // Asynchronous reset mid-scan
    @(negedge clk);
    mask = 5'b11111; dwell = 4'd1; pat = 5'b11111; en = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_frame", 32'(frame), 32'd0);
    chk("arst_fv", 32'(frame_valid), 32'd0);
    en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_scan(5'b11111, 4'd0, 5'b01101, 40, ve, vf, sb);
    chk("arst_edge", 32'(ve), 32'd6);
    chk("arst_frame2", 32'(vf), 32'b01101);

    // Back-to-back scans with en held high
    @(negedge clk);
    mask = 5'b11111; dwell = 4'd0; pat = 5'b10011; en = 1'b1;
    fv_edges.delete();
    for (int k = 1; k <= 40 && fv_edges.size() < 3; k++) begin
      @(posedge clk); #1;
      if (frame_valid) fv_edges.push_back(k);
    end
    chk("b2b_count", 32'(fv_edges.size()), 32'd3);
    if (fv_edges.size() == 3) begin
      chk("b2b_first", 32'(fv_edges[0]), 32'd6);
      chk("b2b_gap1", 32'(fv_edges[1] - fv_edges[0]), 32'd6);
      chk("b2b_gap2", 32'(fv_edges[2] - fv_edges[1]), 32'd6);
    end
    @(negedge clk); en = 1'b0;
    @(negedge clk);

    // Random traffic: inputs change freely mid-scan, model tracks latching
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      en    = ($urandom_range(0, 7) != 0);
      mask  = 5'($urandom);
      dwell = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 2));
      pat   = 5'($urandom);
    end
    @(negedge clk); en = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule : tb_scan_sel_5
`default_nettype wire
